// File: rtl/arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   - state_e  : arbiter FSM states (IDLE, XFER, RESP)
//   - SZ_*     : data access size codes as presented on dm_size
//   - owner_e  : which requester currently owns the RAM port
//   - size_to_len : byte count of an access; the unused code 11 is a word
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/byte_sequencer.sv
// Byte-serial datapath for one RAM access.
// Latches base address, length and write data on load_i, then walks the
// access one byte per step_i, most significant byte first (big-endian).
//   clk_i, rst_i  : clock, synchronous active-high reset
//   load_i        : start a new access (addr_i, wdata_i, len_i captured)
//   step_i        : current byte is on the RAM bus this cycle
//   ram_rdata_i   : RAM read byte for the address currently presented
//   last_o        : the byte on the bus is the final one of the access
//   rdata_o       : assembled read value including the current byte
//   ram_addr_o    : registered RAM byte address (wraps modulo 2^ADDR_W)
//   ram_wdata_o   : registered RAM write byte
module byte_sequencer
    import arb_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [2:0]        len_i,
    input  logic [7:0]        ram_rdata_i,
    output logic              last_o,
    output logic [31:0]       rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_wdata_o
);

    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        len_q;
    logic [31:0]       wdata_q;
    logic [31:0]       shift_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_wdata_q;

    logic [1:0] cnt_d;
    logic [1:0] ld_idx;
    logic [1:0] nxt_idx;

    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[8*idx +: 8];
    endfunction

    always_comb begin
        cnt_d   = cnt_q + 2'd1;
        // Byte k of an L-byte access comes from wdata[8*(L-1-k) +: 8].
        ld_idx  = 2'(len_i - 3'd1);
        nxt_idx = 2'(len_q - 3'd2 - {1'b0, cnt_q});
        last_o  = ({1'b0, cnt_q} == (len_q - 3'd1));
        // shift_q is zeroed on load, so short reads come out zero-extended.
        rdata_o = {shift_q[23:0], ram_rdata_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= 2'd0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 8'd0;
        end else if (load_i) begin
            cnt_q       <= 2'd0;
            ram_addr_q  <= addr_i;
            ram_wdata_q <= sel_byte(wdata_i, ld_idx);
        end else if (step_i && !last_o) begin
            cnt_q       <= cnt_d;
            ram_addr_q  <= base_q + ADDR_W'(cnt_d);
            ram_wdata_q <= sel_byte(wdata_q, nxt_idx);
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_i) begin
            base_q  <= addr_i;
            len_q   <= len_i;
            wdata_q <= wdata_i;
            shift_q <= 32'd0;
        end else if (step_i) begin
            shift_q <= rdata_o;
        end
    end

    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port byte RAM between instruction fetch (IF) and data
// access (DM). One requester is granted at a time; each 8/16/32-bit access
// runs as consecutive big-endian byte cycles, then a one-cycle done pulse.
//   CLK, CLR              : clock, synchronous active-high reset
//   if_req/if_addr        : fetch request (always a word) and byte address
//   if_rdata/if_done      : fetched word and its completion pulse
//   dm_req/dm_rw/dm_size  : data request, 1 = write, 00/01/10(11) = B/H/W
//   dm_addr/dm_wdata      : data byte address, right-aligned write data
//   dm_rdata/dm_done      : right-aligned zero-extended read data, pulse
//   ram_*                 : RAM port (combinational read, write on ram_rw)
//   stall_if/stall_mem    : requester waiting or being served
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int MAX_DM_RUN = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_rw,
    input  logic [1:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_done,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int RUN_W = (MAX_DM_RUN < 2) ? 1 : $clog2(MAX_DM_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);

    state_e           state_q;
    owner_e           owner_q;
    logic [RUN_W-1:0] run_cnt_q;
    logic [RUN_W-1:0] run_cnt_d;
    logic             if_done_q;
    logic             dm_done_q;
    logic [31:0]      if_rdata_q;
    logic [31:0]      dm_rdata_q;
    logic             ram_en_q;
    logic             ram_rw_q;

    logic              grant_dm;
    logic              grant_if;
    logic              seq_load;
    logic              seq_step;
    logic              seq_last;
    logic [ADDR_W-1:0] seq_addr;
    logic [2:0]        seq_len;
    logic [31:0]       seq_rdata;

    always_comb begin
        // DM normally wins; IF takes the port once DM has had MAX_DM_RUN
        // grants in a row while IF was waiting.
        grant_dm  = dm_req && !(if_req && (run_cnt_q == RUN_MAX));
        grant_if  = if_req && !grant_dm;
        seq_load  = (state_q == IDLE) && (grant_dm || grant_if);
        seq_step  = (state_q == XFER);
        seq_addr  = grant_dm ? dm_addr : if_addr;
        seq_len   = grant_dm ? size_to_len(dm_size) : 3'd4;
        run_cnt_d = run_cnt_q;
        if (grant_if || !if_req) begin
            run_cnt_d = '0;
        end else if (run_cnt_q != RUN_MAX) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end
    end

    byte_sequencer #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk_i       (CLK),
        .rst_i       (CLR),
        .load_i      (seq_load),
        .step_i      (seq_step),
        .addr_i      (seq_addr),
        .wdata_i     (dm_wdata),
        .len_i       (seq_len),
        .ram_rdata_i (ram_rdata),
        .last_o      (seq_last),
        .rdata_o     (seq_rdata),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            run_cnt_q  <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= 32'd0;
            ram_en_q   <= 1'b0;
            ram_rw_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (seq_load) begin
                        state_q   <= XFER;
                        owner_q   <= grant_dm ? OWN_DM : OWN_IF;
                        run_cnt_q <= run_cnt_d;
                        ram_en_q  <= 1'b1;
                        ram_rw_q  <= grant_dm && dm_rw;
                    end
                end
                XFER: begin
                    // Done and read data are registered here so they appear
                    // together during the RESP cycle.
                    if (seq_last) begin
                        state_q  <= RESP;
                        ram_en_q <= 1'b0;
                        ram_rw_q <= 1'b0;
                        if (owner_q == OWN_DM) begin
                            dm_done_q <= 1'b1;
                            if (!ram_rw_q) begin
                                dm_rdata_q <= seq_rdata;
                            end
                        end else begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= seq_rdata;
                        end
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    if_done_q <= 1'b0;
                    dm_done_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_rw    = ram_rw_q;
    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    typedef struct {
        bit        rw;
        int        len;
        bit [7:0]  addr;
        bit [31:0] wdata;
    } txn_t;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        if_req;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_rw;
    logic [1:0]  dm_size;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        ram_en;
    logic        ram_rw;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        stall_if;
    logic        stall_mem;

    bit [7:0] mem     [256];
    bit [7:0] ref_mem [256];
    logic       bd_we;
    logic [7:0] bd_addr;
    logic [7:0] bd_data;

    txn_t     if_q[$];
    txn_t     dm_q[$];
    bit [7:0] seen_a[$];
    bit [7:0] seen_w[$];
    bit       grant_log[$];
    bit [31:0] last_dm_exp;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.ADDR_W(8), .MAX_DM_RUN(2)) dut (
        .CLK(CLK), .CLR(CLR),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_rw(dm_rw), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    initial forever #5 CLK = ~CLK;

    // RAM: combinational read, write at the rising edge; backdoor preload.
    assign ram_rdata = mem[ram_addr];
    always @(posedge CLK) begin
        if (ram_en && ram_rw) mem[ram_addr] <= ram_wdata;
        else if (bd_we)       mem[bd_addr]  <= bd_data;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    function automatic int size_len(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    // Compare one completed access against the memory model.
    task automatic score(input txn_t t, input bit is_dm);
        bit [31:0] exp;
        int n;
        chk(is_dm ? "dm_nbytes" : "if_nbytes", 32'(seen_a.size()), 32'(t.len));
        n = (seen_a.size() < t.len) ? seen_a.size() : t.len;
        for (int k = 0; k < n; k++)
            chk("ram_addr_seq", {24'd0, seen_a[k]}, {24'd0, 8'(int'(t.addr) + k)});
        if (t.rw) begin
            chk("dm_wbytes", 32'(seen_w.size()), 32'(t.len));
            n = (seen_w.size() < t.len) ? seen_w.size() : t.len;
            for (int k = 0; k < n; k++)
                chk("ram_wdata_seq", {24'd0, seen_w[k]}, (t.wdata >> (8 * (t.len - 1 - k))) & 32'hFF);
            for (int k = 0; k < t.len; k++)
                ref_mem[8'(int'(t.addr) + k)] = 8'(t.wdata >> (8 * (t.len - 1 - k)));
            chk("dm_rdata_after_write", dm_rdata, last_dm_exp);
        end else begin
            chk("read_no_write", 32'(seen_w.size()), 32'd0);
            exp = 32'd0;
            for (int k = 0; k < t.len; k++)
                exp = (exp << 8) | {24'd0, ref_mem[8'(int'(t.addr) + k)]};
            if (is_dm) begin
                chk("dm_rdata", dm_rdata, exp);
                last_dm_exp = exp;
            end else begin
                chk("if_rdata", if_rdata, exp);
            end
        end
        seen_a.delete();
        seen_w.delete();
    endtask

    // Monitor: collects RAM bus activity and scores every done pulse.
    initial forever begin
        txn_t t;
        @(negedge CLK);
        if (bd_we) ref_mem[bd_addr] = bd_data;
        if (CLR) begin
            seen_a.delete();
            seen_w.delete();
            last_dm_exp = 32'd0;
        end else begin
            if (ram_en) begin
                seen_a.push_back(ram_addr);
                if (ram_rw) seen_w.push_back(ram_wdata);
            end
            if (if_done) begin
                grant_log.push_back(1'b0);
                if (if_q.size() == 0) fail_now("if_done_unexpected");
                else begin t = if_q.pop_front(); score(t, 1'b0); end
            end
            if (dm_done) begin
                grant_log.push_back(1'b1);
                if (dm_q.size() == 0) fail_now("dm_done_unexpected");
                else begin t = dm_q.pop_front(); score(t, 1'b1); end
            end
        end
    end

    // All stimulus tasks are entered and left just after a rising edge.
    task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge CLK); #1;
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        CLR = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0;
    endtask

    task automatic do_if(input logic [7:0] a, output int cyc, output int nst);
        txn_t t;
        t.rw = 1'b0; t.len = 4; t.addr = a; t.wdata = 32'd0;
        if_q.push_back(t);
        if_req = 1'b1; if_addr = a;
        cyc = -1; nst = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            if (if_done) begin cyc = c; break; end
            if (stall_if) nst++;
        end
        if (cyc < 0) fail_now("if_done_timeout");
        @(posedge CLK); #1;
        if_req = 1'b0; if_addr = 8'($urandom);
    endtask

    task automatic do_dm(input logic rw, input logic [1:0] sz, input logic [7:0] a,
                         input logic [31:0] wd, output int cyc, output int nst);
        txn_t t;
        t.rw = rw; t.len = size_len(sz); t.addr = a; t.wdata = wd;
        dm_q.push_back(t);
        dm_req = 1'b1; dm_rw = rw; dm_size = sz; dm_addr = a; dm_wdata = wd;
        cyc = -1; nst = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            if (dm_done) begin cyc = c; break; end
            if (stall_mem) nst++;
        end
        if (cyc < 0) fail_now("dm_done_timeout");
        @(posedge CLK); #1;
        dm_req = 1'b0; dm_wdata = $urandom; dm_addr = 8'($urandom);
    endtask

    initial begin
        int cyc, nst, c1, c2, s2, ndone, mism;
        logic [3:0] order;
        txn_t t;

        CLR = 1'b1; bd_we = 1'b0; bd_addr = 8'd0; bd_data = 8'd0;
        if_req = 1'b0; if_addr = 8'd0;
        dm_req = 1'b0; dm_rw = 1'b0; dm_size = 2'b00; dm_addr = 8'd0; dm_wdata = 32'd0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_done", {30'd0, if_done, dm_done}, 32'd0);
        chk("rst_ram_ctl", {30'd0, ram_en, ram_rw}, 32'd0);
        chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        chk("rst_stalls", {30'd0, stall_if, stall_mem}, 32'd0);
        @(posedge CLK); #1;
        CLR = 1'b0;

        for (int i = 0; i < 256; i++) bd_write(8'(i), 8'($urandom));

        // Word fetch from 0x00, cycle by cycle.
        bd_write(8'h00, 8'hE3); bd_write(8'h01, 8'hA0);
        bd_write(8'h02, 8'h10); bd_write(8'h03, 8'h05);
        t.rw = 1'b0; t.len = 4; t.addr = 8'h00; t.wdata = 32'd0;
        if_q.push_back(t);
        if_req = 1'b1; if_addr = 8'h00;
        for (int c = 0; c <= 5; c++) begin
            @(negedge CLK);
            chk("fetch_stall_if", {31'd0, stall_if}, (c <= 4) ? 32'd1 : 32'd0);
            chk("fetch_ram_en", {31'd0, ram_en}, (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
            chk("fetch_if_done", {31'd0, if_done}, (c == 5) ? 32'd1 : 32'd0);
            if (c >= 1 && c <= 4) chk("fetch_ram_addr", {24'd0, ram_addr}, 32'(c - 1));
        end
        chk("fetch_if_rdata", if_rdata, 32'hE3A01005);
        @(posedge CLK); #1;
        if_req = 1'b0;
        @(negedge CLK);
        chk("fetch_done_pulse", {31'd0, if_done}, 32'd0);
        chk("fetch_rdata_held", if_rdata, 32'hE3A01005);
        @(posedge CLK); #1;

        // Halfword write wrapping from 0xFF to 0x00.
        do_dm(1'b1, 2'b01, 8'hFF, 32'h0000ABCD, cyc, nst);
        chk("wr_latency", 32'(cyc), 32'd3);
        chk("wr_stall_mem", 32'(nst), 32'd3);
        chk("wr_mem_ff", {24'd0, mem[255]}, 32'h000000AB);
        chk("wr_mem_00", {24'd0, mem[0]}, 32'h000000CD);

        // Size code 11 behaves as a word read.
        bd_write(8'h50, 8'h12); bd_write(8'h51, 8'h34);
        bd_write(8'h52, 8'h56); bd_write(8'h53, 8'h78);
        do_dm(1'b0, 2'b11, 8'h50, 32'd0, cyc, nst);
        chk("sz11_latency", 32'(cyc), 32'd5);
        chk("sz11_rdata", dm_rdata, 32'h12345678);

        // Request dropped and inputs changed after the grant.
        bd_write(8'h30, 8'hDE); bd_write(8'h31, 8'hAD);
        bd_write(8'h32, 8'hBE); bd_write(8'h33, 8'hEF);
        t.rw = 1'b0; t.len = 4; t.addr = 8'h30; t.wdata = 32'd0;
        dm_q.push_back(t);
        dm_req = 1'b1; dm_rw = 1'b0; dm_size = 2'b10; dm_addr = 8'h30;
        @(negedge CLK);
        @(posedge CLK); #1;
        dm_req = 1'b0; dm_rw = 1'b1; dm_size = 2'b00; dm_addr = 8'h77; dm_wdata = $urandom;
        cyc = -1;
        for (int c = 1; c < 50; c++) begin
            @(negedge CLK);
            if (dm_done) begin cyc = c; break; end
        end
        chk("drop_latency", 32'(cyc), 32'd5);
        chk("drop_rdata", dm_rdata, 32'hDEADBEEF);
        @(posedge CLK); #1;

        // Simultaneous byte read and fetch: data first, fetch after its RESP.
        bd_write(8'h10, 8'h9C);
        fork
            begin do_dm(1'b0, 2'b00, 8'h10, 32'd0, c1, nst); end
            begin do_if(8'h20, c2, s2); end
        join
        chk("simul_dm_latency", 32'(c1), 32'd2);
        chk("simul_if_latency", 32'(c2), 32'd8);
        chk("simul_if_stall", 32'(s2), 32'd8);
        chk("simul_dm_rdata", dm_rdata, 32'h0000009C);

        // Starvation limit with a continuously requesting data port.
        do_reset();
        grant_log.delete();
        fork
            begin
                int cc, ss;
                for (int i = 0; i < 3; i++) do_dm(1'b0, 2'b10, 8'($urandom), 32'd0, cc, ss);
            end
            begin
                int cc, ss;
                do_if(8'($urandom), cc, ss);
            end
        join
        chk("starve_ngrants", 32'(grant_log.size()), 32'd4);
        order = {grant_log[0], grant_log[1], grant_log[2], grant_log[3]};
        chk("starve_order", {28'd0, order}, 32'b1101);

        // Reset lands on the edge that would present the third write byte.
        bd_write(8'h40, 8'h11); bd_write(8'h41, 8'h11);
        bd_write(8'h42, 8'h11); bd_write(8'h43, 8'h11);
        dm_req = 1'b1; dm_rw = 1'b1; dm_size = 2'b10; dm_addr = 8'h40; dm_wdata = 32'hA1B2C3D4;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        CLR = 1'b1; dm_req = 1'b0;
        @(posedge CLK); #1;
        CLR = 1'b0;
        @(negedge CLK);
        chk("rstx_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rstx_dm_rdata", dm_rdata, 32'd0);
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (dm_done) ndone++;
            @(negedge CLK);
        end
        chk("rstx_no_done", 32'(ndone), 32'd0);
        chk("rstx_mem40", {24'd0, mem[8'h40]}, 32'hA1);
        chk("rstx_mem41", {24'd0, mem[8'h41]}, 32'hB2);
        chk("rstx_mem42", {24'd0, mem[8'h42]}, 32'h11);
        chk("rstx_mem43", {24'd0, mem[8'h43]}, 32'h11);
        ref_mem[8'h40] = 8'hA1;
        ref_mem[8'h41] = 8'hB2;
        @(posedge CLK); #1;
        do_dm(1'b0, 2'b00, 8'h41, 32'd0, cyc, nst);
        chk("rstx_idle_latency", 32'(cyc), 32'd2);

        // Randomized concurrent traffic from both requesters.
        fork
            begin
                int cc, ss;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
                    do_if(8'($urandom), cc, ss);
                end
            end
            begin
                int cc, ss;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
                    do_dm(1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), $urandom, cc, ss);
                end
            end
        join

        repeat (3) @(negedge CLK);
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != ref_mem[i]) mism++;
        chk("final_ram_image", 32'(mism), 32'd0);
        chk("final_queues_empty", 32'(if_q.size() + dm_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 256x8 byte RAM between the IF-stage instruction fetch and the MEM-stage data access, so the pipeline can run on one unified memory.
- Grants one requester at a time and sequences each 8/16/32-bit access as consecutive byte cycles, big-endian.
- Drives stall outputs to the hazard unit while a requester is waiting or being served.

Parameters:
- ADDR_W, 8, RAM byte-address width; addresses wrap modulo 2^ADDR_W.
- MAX_DM_RUN, 2, maximum consecutive data grants while an IF request is pending; the next grant then goes to IF.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  synchronous active-high reset.
- if_req  in  1  instruction fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch byte address.
- if_rdata  out  32  fetched word, valid when if_done; held until the next IF completion.
- if_done  out  1  one-cycle completion pulse.
- dm_req  in  1  data access request; held until dm_done.
- dm_rw  in  1  1 = write, 0 = read.
- dm_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- dm_addr  in  ADDR_W  data byte address.
- dm_wdata  in  32  write data, right-aligned.
- dm_rdata  out  32  read data, right-aligned and zero-extended; valid when dm_done; held until the next data read completes.
- dm_done  out  1  one-cycle completion pulse.
- ram_en  out  1  RAM enable.
- ram_rw  out  1  RAM write strobe, 1 = write.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wdata  out  8  RAM write byte.
- ram_rdata  in  8  RAM read byte; combinational read, valid in the same cycle as ram_addr.
- stall_if  out  1  if_req & ~if_done.
- stall_mem  out  1  dm_req & ~dm_done.

Behaviour:
- Reset (CLR high at a rising edge):
  - State goes to IDLE; byte counter and run counter clear to 0.
  - if_rdata and dm_rdata clear to 0; if_done, dm_done, ram_en and ram_rw clear to 0; ram_addr and ram_wdata clear to 0.
  - A transfer in flight is aborted with no done pulse; bytes already written stay written.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - Arbitrates and latches owner, address, length L and write data; moves to XFER.
  - Priority goes to dm_req, unless if_req is pending and run_cnt == MAX_DM_RUN, in which case IF wins.
  - With no request, stays in IDLE with ram_en = 0.
- XFER:
  - One byte per cycle for k = 0..L-1, where L = 1, 2 or 4 (IF is always 4).
  - ram_en = 1 and ram_addr = (addr + k) mod 2^ADDR_W.
  - Read: shift register <= {shift[23:0], ram_rdata}.
  - Write: ram_rw = 1 and ram_wdata = wdata[8*(L-1-k) +: 8].
  - After byte L-1, moves to RESP.
- RESP:
  - Pulses done for the owner for exactly one cycle; on a read, the owner's rdata is updated from the shift register.
  - Returns to IDLE.
  - ram_en = 0 in both RESP and IDLE.
- Latency from request visible in IDLE to done: L+1 cycles (word = 5, byte = 2). Between back-to-back accesses, the arbiter spends one IDLE cycle.
- run_cnt:
  - Increments on a data grant while if_req = 1, saturating at MAX_DM_RUN.
  - Clears on any IF grant, or on a data grant while if_req = 0.
- Requester behaviour:
  - Dropping req mid-transfer does not abort; the transfer completes and done still pulses.
  - Address and data changes after the grant are ignored (latched values are used).
- Simultaneous requests in IDLE: exactly one grant; the loser stalls and is served after the next RESP.
- A write never updates dm_rdata.

Decomposition:
- Shared package arb_pkg:
  - state encoding (IDLE/XFER/RESP);
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD;
  - owner codes OWN_IF, OWN_DM;
  - a size-to-length function.
- One natural sub-module, byte_sequencer: holds the byte counter, address increment/wrap, shift-in assembly and write-byte select. The arbiter top holds the FSM, priority and run counter.

Test Plan:
- Word fetch: IF-only with if_addr = 0x00 and RAM[0..3] = E3,A0,10,05 -> ram_addr 00..03 on cycles 1-4; if_done on cycle 5 with if_rdata = 0xE3A01005; stall_if high on cycles 0-4.
- Data write: dm_req with rw = 1, size = 01, addr = 0xFF, wdata = 0x0000ABCD -> RAM[FF] = AB and RAM[00] = CD (address wrap); dm_done after 3 cycles; dm_rdata unchanged.
- Simultaneous requests: dm byte read at 0x10 (RAM = 0x9C) together with an IF fetch -> dm served first, dm_rdata = 0x0000009C; IF is granted in the IDLE after dm's RESP, and stall_if stays high throughout.
- Starvation limit: dm_req held continuously plus if_req, MAX_DM_RUN = 2 -> grant order DM, DM, IF, DM.
- Reset mid-transfer: CLR asserted during XFER byte 2 of a word write -> no done; ram_en = 0 next cycle; bytes 0-1 written, bytes 2-3 not written; state IDLE.
- Illegal size: dm_size = 11 read -> 4 byte cycles, identical to a word read.
